bsg_parallel_in_serial_out_multi: RTL

- Multi-enque, single-deque shifting FIFO. It is the transmit-side counterpart of the serial-in/parallel-out multi-deque FIFO.
- Upstream offers 0..in_els_p words per cycle on lanes 0..n-1. The block accepts as many as fit and drains one word per cycle to a valid/yumi consumer.
- It sits where a wide datapath feeds a narrow link, for example ahead of a serializer or a one-word-per-cycle network port.

---
 rtl/bsg_parallel_in_serial_out_multi.sv | 72 +++++++
 1 files changed

// File: rtl/bsg_parallel_in_serial_out_multi.sv
// bsg_parallel_in_serial_out_multi: multi-lane enqueue, single-word dequeue shifting FIFO.
module bsg_parallel_in_serial_out_multi #(
   parameter int width_p  = 1,
   parameter int els_p    = 1,
   parameter int in_els_p = els_p
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic [$clog2(in_els_p+1)-1:0] v_cnt_i,
   input  logic [in_els_p*width_p-1:0]   data_i,
   output logic [$clog2(in_els_p+1)-1:0] yumi_cnt_o,
   output logic                          valid_o,
   output logic [width_p-1:0]            data_o,
   input  logic                          yumi_i,
   output logic [$clog2(els_p+1)-1:0]    count_o
);
   localparam int cnt_w = $clog2(in_els_p+1);
   localparam int ptr_w = $clog2(els_p+1);
   localparam int idx_w = ptr_w + 1;

   logic [width_p-1:0] data_q [els_p];
   logic [width_p-1:0] data_d [els_p];
   logic [els_p-1:0]   valid_q, valid_d;
   logic [ptr_w-1:0]   count_q;
   logic [idx_w-1:0]   free, base, count_d;
   logic               deq;

   if (els_p < in_els_p) begin : g_bad_depth
      $error("els_p must be >= in_els_p");
   end

   assign valid_o = valid_q[0];
   assign data_o  = data_q[0];
   assign count_o = count_q;
   assign deq     = yumi_i & valid_o;
   // free space comes only from registered occupancy, keeping yumi_i off the accept path
   assign free       = idx_w'(els_p) - idx_w'(count_q);
   assign yumi_cnt_o = !reset_n_i ? '0 : (idx_w'(v_cnt_i) > free) ? cnt_w'(free) : v_cnt_i;
   assign base       = idx_w'(count_q) - idx_w'(deq);
   assign count_d    = base + idx_w'(yumi_cnt_o);

   always_comb begin
      data_d  = data_q;
      valid_d = '0;
      for (int i = 0; i < els_p-1; i++)
         if (deq) data_d[i] = data_q[i+1];
      for (int k = 0; k < in_els_p; k++)
         for (int i = 0; i < els_p; i++)
            if (idx_w'(k) < idx_w'(yumi_cnt_o) && base + idx_w'(k) == idx_w'(i))
               data_d[i] = data_i[k*width_p +: width_p];
      for (int i = 0; i < els_p; i++)
         valid_d[i] = idx_w'(i) < count_d;
   end

   always_ff @(posedge clk_i) begin
      data_q <= data_d;
      if (!reset_n_i) begin
         count_q <= '0;
         valid_q <= '0;
      end else begin
         count_q <= count_d[ptr_w-1:0];
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk_i)
      if (reset_n_i) begin
         assert (!(yumi_i && !valid_o)) else $error("yumi_i asserted while empty");
         assert (v_cnt_i <= cnt_w'(in_els_p)) else $error("v_cnt_i exceeds in_els_p");
         assert (32'(count_q) == $countones(valid_q)) else $error("count/valid disagree");
      end
endmodule
